// File: rtl/argon_pkg.sv
// Opcode encodings and the response record shared by the argon ALU and its arbiter.
package argon_pkg;

   localparam int ARGON_DW = 16;

   localparam logic [3:0] OP_ADD     = 4'd0;
   localparam logic [3:0] OP_SUB     = 4'd1;
   localparam logic [3:0] OP_AND     = 4'd2;
   localparam logic [3:0] OP_OR      = 4'd3;
   localparam logic [3:0] OP_XOR     = 4'd4;
   localparam logic [3:0] OP_SLL     = 4'd5;
   localparam logic [3:0] OP_SRL     = 4'd6;
   localparam logic [3:0] OP_SLT     = 4'd7;
   localparam logic [3:0] OP_SLTU    = 4'd8;
   localparam logic [3:0] OP_INVALID = 4'd9;
   localparam logic [3:0] OP_BEQ     = 4'd10;
   localparam logic [3:0] OP_BNE     = 4'd11;
   localparam logic [3:0] OP_BLT     = 4'd12;
   localparam logic [3:0] OP_BGE     = 4'd13;
   localparam logic [3:0] OP_BGEU    = 4'd14;
   localparam logic [3:0] OP_BLTU    = 4'd15;

   typedef struct packed {
      logic [ARGON_DW-1:0] result;
      logic                branch;
      logic                invalid;
   } argon_rsp_t;

endpackage

// File: rtl/argon_alu_core.sv
// Purely combinational ALU: arithmetic ops produce a result, branch ops produce
// a taken flag, and any unassigned opcode raises the invalid flag.
module argon_alu_core
   import argon_pkg::*;
#(
   parameter int OPWIDTH   = 4,
   parameter int DATAWIDTH = 16
) (
   input  logic [OPWIDTH-1:0]   op_i,
   input  logic [DATAWIDTH-1:0] a_i,
   input  logic [DATAWIDTH-1:0] b_i,
   output logic [DATAWIDTH-1:0] result_o,
   output logic                 branch_o,
   output logic                 invalid_o
);

   localparam logic [DATAWIDTH-1:0] SHIFT_LIMIT = DATAWIDTH'(DATAWIDTH);

   logic shiftOver;
   logic ltSigned;
   logic ltUnsigned;

   assign shiftOver  = (b_i >= SHIFT_LIMIT);
   assign ltSigned   = ($signed(a_i) < $signed(b_i));
   assign ltUnsigned = (a_i < b_i);

   always_comb begin
      result_o  = '0;
      branch_o  = 1'b0;
      invalid_o = 1'b0;
      case (op_i)
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_SLL:  result_o = shiftOver ? '0 : (a_i << b_i);
         OP_SRL:  result_o = shiftOver ? '0 : (a_i >> b_i);
         OP_SLT:  result_o[0] = ltSigned;
         OP_SLTU: result_o[0] = ltUnsigned;
         OP_BEQ:  branch_o = (a_i == b_i);
         OP_BNE:  branch_o = (a_i != b_i);
         OP_BLT:  branch_o = ltSigned;
         OP_BGE:  branch_o = ~ltSigned;
         OP_BGEU: branch_o = ~ltUnsigned;
         OP_BLTU: branch_o = ltUnsigned;
         default: invalid_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/argon_alu_arbiter.sv
// Two requesters share one ALU, each with a one-deep response slot.
// Define ARGON_ALU_ARB_RR_EN for round-robin grant; otherwise port 0 has fixed priority.
module argon_alu_arbiter
   import argon_pkg::*;
#(
   parameter int OPWIDTH   = 4,
   parameter int DATAWIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_req0_valid,
   output logic                 o_req0_ready,
   input  logic [OPWIDTH-1:0]   i_req0_op,
   input  logic [DATAWIDTH-1:0] i_req0_a,
   input  logic [DATAWIDTH-1:0] i_req0_b,
   input  logic                 i_req1_valid,
   output logic                 o_req1_ready,
   input  logic [OPWIDTH-1:0]   i_req1_op,
   input  logic [DATAWIDTH-1:0] i_req1_a,
   input  logic [DATAWIDTH-1:0] i_req1_b,
   output logic                 o_rsp0_valid,
   input  logic                 i_rsp0_ready,
   output logic [DATAWIDTH-1:0] o_rsp0_result,
   output logic                 o_rsp0_branch,
   output logic                 o_rsp0_invalid,
   output logic                 o_rsp1_valid,
   input  logic                 i_rsp1_ready,
   output logic [DATAWIDTH-1:0] o_rsp1_result,
   output logic                 o_rsp1_branch,
   output logic                 o_rsp1_invalid
);

   logic                 elig0, elig1;
   logic                 grant0, grant1;
   logic [OPWIDTH-1:0]   aluOp;
   logic [DATAWIDTH-1:0] aluA, aluB, aluResult;
   logic                 aluBranch, aluInvalid;

   logic                 full0_q, full0_d, full1_q, full1_d;
   logic [DATAWIDTH-1:0] result0_q, result0_d, result1_q, result1_d;
   logic                 branch0_q, branch0_d, branch1_q, branch1_d;
   logic                 invalid0_q, invalid0_d, invalid1_q, invalid1_d;

   // A slot being drained this cycle counts as free, so it can refill back-to-back.
   assign elig0 = i_req0_valid & (~full0_q | i_rsp0_ready);
   assign elig1 = i_req1_valid & (~full1_q | i_rsp1_ready);

`ifdef ARGON_ALU_ARB_RR_EN
   logic lastGrant_q, lastGrant_d;

   always_comb begin
      grant0      = elig0 & (~elig1 | lastGrant_q);
      grant1      = elig1 & (~elig0 | ~lastGrant_q);
      lastGrant_d = lastGrant_q;
      if (grant0) begin
         lastGrant_d = 1'b0;
      end else if (grant1) begin
         lastGrant_d = 1'b1;
      end
   end

   // Resetting to port 1 makes port 0 the winner of the first tie.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lastGrant_q <= 1'b1;
      end else begin
         lastGrant_q <= lastGrant_d;
      end
   end
`else
   always_comb begin
      grant0 = elig0;
      grant1 = elig1 & ~elig0;
   end
`endif

   assign o_req0_ready = grant0;
   assign o_req1_ready = grant1;

   assign aluOp = grant1 ? i_req1_op : i_req0_op;
   assign aluA  = grant1 ? i_req1_a  : i_req0_a;
   assign aluB  = grant1 ? i_req1_b  : i_req0_b;

   argon_alu_core #(
      .OPWIDTH   (OPWIDTH),
      .DATAWIDTH (DATAWIDTH)
   ) u_alu (
      .op_i      (aluOp),
      .a_i       (aluA),
      .b_i       (aluB),
      .result_o  (aluResult),
      .branch_o  (aluBranch),
      .invalid_o (aluInvalid)
   );

   always_comb begin
      full0_d    = full0_q;
      result0_d  = result0_q;
      branch0_d  = branch0_q;
      invalid0_d = invalid0_q;
      full1_d    = full1_q;
      result1_d  = result1_q;
      branch1_d  = branch1_q;
      invalid1_d = invalid1_q;
      if (grant0) begin
         full0_d    = 1'b1;
         result0_d  = aluResult;
         branch0_d  = aluBranch;
         invalid0_d = aluInvalid;
      end else if (i_rsp0_ready) begin
         full0_d = 1'b0;
      end
      if (grant1) begin
         full1_d    = 1'b1;
         result1_d  = aluResult;
         branch1_d  = aluBranch;
         invalid1_d = aluInvalid;
      end else if (i_rsp1_ready) begin
         full1_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         full0_q    <= 1'b0;
         result0_q  <= '0;
         branch0_q  <= 1'b0;
         invalid0_q <= 1'b0;
         full1_q    <= 1'b0;
         result1_q  <= '0;
         branch1_q  <= 1'b0;
         invalid1_q <= 1'b0;
      end else begin
         full0_q    <= full0_d;
         result0_q  <= result0_d;
         branch0_q  <= branch0_d;
         invalid0_q <= invalid0_d;
         full1_q    <= full1_d;
         result1_q  <= result1_d;
         branch1_q  <= branch1_d;
         invalid1_q <= invalid1_d;
      end
   end

   assign o_rsp0_valid   = full0_q;
   assign o_rsp0_result  = result0_q;
   assign o_rsp0_branch  = branch0_q;
   assign o_rsp0_invalid = invalid0_q;
   assign o_rsp1_valid   = full1_q;
   assign o_rsp1_result  = result1_q;
   assign o_rsp1_branch  = branch1_q;
   assign o_rsp1_invalid = invalid1_q;

endmodule
